im_program_loader: RTL

//  Writer side of the instruction-memory fetch path. Receives a framed byte stream, packs it

---
 rtl/im_program_loader_pkg.sv | 19 +
 rtl/im_program_loader.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/im_program_loader_pkg.sv
// Shared definitions for the instruction-memory loader, the instruction RAM and the control logic.
// Holds the loader state encoding and the default address width, data width and frame start byte.
package im_program_loader_pkg;

  localparam int         IM_ADDR_W = 8;
  localparam int         IM_DATA_W = 16;
  localparam logic [7:0] IM_MAGIC  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_HI   = 3'd2,
    ST_LO   = 3'd3,
    ST_CHK  = 3'd4,
    ST_DONE = 3'd5,
    ST_ERR  = 3'd6
  } ld_state_e;

endpackage

// File: rtl/im_program_loader.sv
// Writer side of the instruction fetch path: unpacks a framed byte stream into 16-bit words,
// writes them to instruction RAM and holds the CPU in reset until a frame passes its checksum.
module im_program_loader
  import im_program_loader_pkg::*;
#(
  parameter int         ADDR_W    = IM_ADDR_W,
  parameter int         DATA_W    = IM_DATA_W,
  parameter logic [7:0] MAGIC     = IM_MAGIC,
  parameter bit         BOOT_HOLD = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  input  logic [7:0]        in_data_i,
  output logic              in_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_waddr_o,
  output logic [DATA_W-1:0] im_wdata_o,
  output logic              cpu_rstn_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W:0]   words_loaded_o
);

  localparam logic [ADDR_W:0]   ONE_W = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [7:0]        xor_q, xor_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              rstn_q, rstn_d;
  logic              done_q, done_d;
  logic              err_q, err_d;

  logic              accept;
  logic [ADDR_W:0]   n_eff;
  logic [ADDR_W:0]   words_inc;

  // The stream is never stalled: one RAM write per two bytes cannot overrun.
  assign in_ready_o = ~rst_i;
  assign accept     = in_valid_i & in_ready_o;
  assign words_inc  = words_q + ONE_W;

  // LEN of zero means a full 2**ADDR_W-word image.
  always_comb begin
    n_eff = {1'b0, len_q};
    if (len_q == '0) begin
      n_eff = {1'b1, {ADDR_W{1'b0}}};
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      xor_q   <= '0;
      addr_q  <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      rstn_q  <= ~BOOT_HOLD;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      xor_q   <= xor_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      rstn_q  <= rstn_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    xor_d   = xor_q;
    addr_d  = addr_q;
    words_d = words_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    rstn_d  = rstn_q;
    done_d  = done_q;
    err_d   = err_q;

    if (accept) begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (in_data_i == MAGIC) begin
            state_d = ST_LEN;
            rstn_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
            words_d = '0;
            addr_d  = '0;
            xor_d   = '0;
          end
        end
        ST_LEN: begin
          len_d   = ADDR_W'(in_data_i);
          state_d = ST_HI;
        end
        ST_HI: begin
          hi_d    = in_data_i;
          xor_d   = xor_q ^ in_data_i;
          state_d = ST_LO;
        end
        ST_LO: begin
          xor_d   = xor_q ^ in_data_i;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = DATA_W'({hi_q, in_data_i});
          addr_d  = addr_q + ONE_A;
          words_d = words_inc;
          state_d = (words_inc == n_eff) ? ST_CHK : ST_HI;
        end
        ST_CHK: begin
          if (in_data_i == xor_q) begin
            done_d  = 1'b1;
            rstn_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign im_we_o        = we_q;
  assign im_waddr_o     = waddr_q;
  assign im_wdata_o     = wdata_q;
  assign cpu_rstn_o     = rstn_q;
  assign busy_o         = (state_q == ST_LEN) || (state_q == ST_HI) ||
                          (state_q == ST_LO)  || (state_q == ST_CHK);
  assign done_o         = done_q;
  assign err_o          = err_q;
  assign words_loaded_o = words_q;

endmodule
